// File: rtl/dac_play_ctrl.sv
// ============================================================================
// Module   : dac_play_ctrl
// Brief    : Playback controller. Loads a waveform from the Ethernet RX FIFO
//            into the DDR write FIFO, then streams it from the DDR read FIFO
//            to the DAC on each DAC request, once or in a loop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_play_ctrl #(
    parameter int DATA_W     = 16,
    parameter int CLR_CYCLES = 10,
    parameter int CLR_PULSE  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_play,
    input  logic              stop_play,
    input  logic [31:0]       set_play_num,
    input  logic              loop_en,
    input  logic              eth_rxfifo_empty,
    input  logic [DATA_W-1:0] eth_rxfifo_dout,
    output logic              eth_rxfifo_rdreq,
    input  logic              wrfifo_full,
    output logic              wrfifo_clr,
    output logic              wrfifo_wren,
    output logic [DATA_W-1:0] wrfifo_din,
    input  logic              rdfifo_empty,
    input  logic [DATA_W-1:0] rdfifo_dout,
    output logic              rdfifo_clr,
    output logic              rdfifo_rden,
    input  logic              dac_data_req,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_data_vld,
    output logic              play_busy,
    output logic              play_done_pulse,
    output logic              underrun_flag
);

    localparam int CLR_W = $clog2(CLR_CYCLES + 1);
    localparam logic [CLR_W-1:0] c_CLR_LAST  = CLR_W'(CLR_CYCLES - 1);
    localparam logic [CLR_W-1:0] c_CLR_PULSE = CLR_W'(CLR_PULSE);
    localparam logic [CLR_W-1:0] c_CLR_ONE   = CLR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_CLR = 3'd1,
        S_LOAD   = 3'd2,
        S_RD_CLR = 3'd3,
        S_PLAY   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            r_state;
    logic [31:0]       r_num;
    logic [CLR_W-1:0]  r_clr_cnt;
    logic [31:0]       r_req_cnt;
    logic [31:0]       r_wr_cnt;
    logic [31:0]       r_play_cnt;
    logic              r_wren;
    logic              r_rd_pend;
    logic              r_wrfifo_clr;
    logic              r_rdfifo_clr;
    logic [DATA_W-1:0] r_dac_data;
    logic              r_dac_vld;
    logic              r_underrun;

    logic              w_rdreq;
    logic              w_rden;
    logic [31:0]       w_rd_inflight;
    logic              w_wr_last;
    logic              w_play_last;
    logic [CLR_W-1:0]  w_clr_next;
    logic              w_clr_end;
    logic              w_clr_pulse_next;

    // The pending read is counted so a back-to-back request cannot over-read the last sample.
    assign w_rd_inflight    = {{31{1'b0}}, r_rd_pend};
    assign w_rdreq          = (r_state == S_LOAD) && !eth_rxfifo_empty && !wrfifo_full
                              && (r_req_cnt < r_num);
    assign w_rden           = (r_state == S_PLAY) && dac_data_req && !rdfifo_empty
                              && ((r_play_cnt + w_rd_inflight) < r_num);
    assign w_wr_last        = r_wren && ((r_wr_cnt + 32'd1) >= r_num);
    assign w_play_last      = r_rd_pend && ((r_play_cnt + 32'd1) >= r_num);
    assign w_clr_next       = r_clr_cnt + c_CLR_ONE;
    assign w_clr_end        = (r_clr_cnt == c_CLR_LAST);
    assign w_clr_pulse_next = !w_clr_end && (w_clr_next < c_CLR_PULSE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_num        <= 32'd0;
            r_clr_cnt    <= '0;
            r_req_cnt    <= 32'd0;
            r_wr_cnt     <= 32'd0;
            r_play_cnt   <= 32'd0;
            r_wren       <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_wrfifo_clr <= 1'b0;
            r_rdfifo_clr <= 1'b0;
            r_dac_data   <= '0;
            r_dac_vld    <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            // Reads issued in the stop cycle are dropped; earlier ones still complete.
            r_wren    <= w_rdreq && !stop_play;
            r_rd_pend <= w_rden && !stop_play;
            r_dac_vld <= 1'b0;

            if (r_rd_pend) begin
                r_dac_data <= rdfifo_dout;
                r_dac_vld  <= 1'b1;
                r_play_cnt <= r_play_cnt + 32'd1;
            end
            if (w_rdreq) begin
                r_req_cnt <= r_req_cnt + 32'd1;
            end
            if (r_wren) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
            if ((r_state == S_PLAY) && dac_data_req && rdfifo_empty) begin
                r_underrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_clr_cnt  <= '0;
                    r_req_cnt  <= 32'd0;
                    r_wr_cnt   <= 32'd0;
                    r_play_cnt <= 32'd0;
                    if (start_play && !stop_play && (set_play_num != 32'd0)) begin
                        r_num        <= set_play_num;
                        r_underrun   <= 1'b0;
                        r_wrfifo_clr <= 1'b1;
                        r_state      <= S_WR_CLR;
                    end
                end

                S_WR_CLR: begin
                    r_wrfifo_clr <= w_clr_pulse_next;
                    if (!w_clr_end) begin
                        r_clr_cnt <= w_clr_next;
                    end else if (!wrfifo_full) begin
                        r_clr_cnt <= '0;
                        r_state   <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (w_wr_last) begin
                        r_clr_cnt    <= '0;
                        r_rdfifo_clr <= 1'b1;
                        r_state      <= S_RD_CLR;
                    end
                end

                S_RD_CLR: begin
                    r_rdfifo_clr <= w_clr_pulse_next;
                    if (!w_clr_end) begin
                        r_clr_cnt <= w_clr_next;
                    end else if (!rdfifo_empty) begin
                        r_clr_cnt <= '0;
                        r_state   <= S_PLAY;
                    end
                end

                S_PLAY: begin
                    if (w_play_last) begin
                        if (loop_en) begin
                            r_play_cnt   <= 32'd0;
                            r_clr_cnt    <= '0;
                            r_rdfifo_clr <= 1'b1;
                            r_state      <= S_RD_CLR;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (stop_play && (r_state != S_IDLE)) begin
                r_state      <= S_IDLE;
                r_wrfifo_clr <= 1'b0;
                r_rdfifo_clr <= 1'b0;
            end
        end
    end

    assign eth_rxfifo_rdreq = w_rdreq;
    assign wrfifo_clr       = r_wrfifo_clr;
    assign wrfifo_wren      = r_wren;
    // Source data is valid the cycle after rdreq, exactly when the write enable is up.
    assign wrfifo_din       = r_wren ? eth_rxfifo_dout : '0;
    assign rdfifo_clr       = r_rdfifo_clr;
    assign rdfifo_rden      = w_rden;
    assign dac_data         = r_dac_data;
    assign dac_data_vld     = r_dac_vld;
    assign play_busy        = (r_state != S_IDLE);
    assign play_done_pulse  = (r_state == S_DONE);
    assign underrun_flag    = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_dac_play_ctrl.sv
// ============================================================================
// Module   : tb_dac_play_ctrl
// Brief    : Directed bench for dac_play_ctrl with Ethernet RX and DDR
//            loopback FIFO models.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dac_play_ctrl;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_play;
    logic              stop_play;
    logic [31:0]       set_play_num;
    logic              loop_en;
    logic              eth_rxfifo_empty;
    logic [DATA_W-1:0] eth_rxfifo_dout = '0;
    logic              eth_rxfifo_rdreq;
    logic              wrfifo_full;
    logic              wrfifo_clr;
    logic              wrfifo_wren;
    logic [DATA_W-1:0] wrfifo_din;
    logic              rdfifo_empty;
    logic [DATA_W-1:0] rdfifo_dout = '0;
    logic              rdfifo_clr;
    logic              rdfifo_rden;
    logic              dac_data_req;
    logic [DATA_W-1:0] dac_data;
    logic              dac_data_vld;
    logic              play_busy;
    logic              play_done_pulse;
    logic              underrun_flag;

    dac_play_ctrl #(.DATA_W(DATA_W), .CLR_CYCLES(10), .CLR_PULSE(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .start_play       (start_play),
        .stop_play        (stop_play),
        .set_play_num     (set_play_num),
        .loop_en          (loop_en),
        .eth_rxfifo_empty (eth_rxfifo_empty),
        .eth_rxfifo_dout  (eth_rxfifo_dout),
        .eth_rxfifo_rdreq (eth_rxfifo_rdreq),
        .wrfifo_full      (wrfifo_full),
        .wrfifo_clr       (wrfifo_clr),
        .wrfifo_wren      (wrfifo_wren),
        .wrfifo_din       (wrfifo_din),
        .rdfifo_empty     (rdfifo_empty),
        .rdfifo_dout      (rdfifo_dout),
        .rdfifo_clr       (rdfifo_clr),
        .rdfifo_rden      (rdfifo_rden),
        .dac_data_req     (dac_data_req),
        .dac_data         (dac_data),
        .dac_data_vld     (dac_data_vld),
        .play_busy        (play_busy),
        .play_done_pulse  (play_done_pulse),
        .underrun_flag    (underrun_flag)
    );

    always #5 clk = ~clk;

    // Ethernet RX FIFO model: one-cycle read latency.
    logic [DATA_W-1:0] eth_mem [0:63];
    int                eth_cnt   = 0;
    int                eth_rd    = 0;
    logic              eth_flush = 1'b0;
    assign eth_rxfifo_empty = (eth_rd >= eth_cnt);
    always @(posedge clk) begin
        if (eth_flush) begin
            eth_rd <= eth_cnt;
        end else if (eth_rxfifo_rdreq && (eth_rd < eth_cnt)) begin
            eth_rxfifo_dout <= eth_mem[eth_rd % 64];
            eth_rd          <= eth_rd + 1;
        end
    end

    // DDR loopback: write FIFO fills memory, read FIFO replays it from the base.
    logic [DATA_W-1:0] ddr_mem [0:63];
    int                ddr_wp = 0;
    int                ddr_rp = 0;
    logic              force_rd_empty = 1'b0;
    assign rdfifo_empty = force_rd_empty || (ddr_rp >= ddr_wp);
    always @(posedge clk) begin
        if (wrfifo_clr) begin
            ddr_wp <= 0;
        end else if (wrfifo_wren) begin
            ddr_mem[ddr_wp % 64] <= wrfifo_din;
            ddr_wp               <= ddr_wp + 1;
        end
        if (rdfifo_clr) begin
            ddr_rp <= 0;
        end else if (rdfifo_rden && (ddr_rp < ddr_wp)) begin
            rdfifo_dout <= ddr_mem[ddr_rp % 64];
            ddr_rp      <= ddr_rp + 1;
        end
    end

    // DAC request strobe, one cycle in four.
    logic dac_en = 1'b0;
    int   dac_ph = 0;
    initial begin
        dac_data_req = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            dac_data_req = dac_en && (dac_ph == 3);
            dac_ph       = (dac_ph + 1) % 4;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              mon_clr = 1'b0;
    int                wr_n, dac_n, done_n, rdreq_n, rdclr_cyc, rdclr_rise;
    int                full_viol, under_reqs, done_cyc, fall_cyc;
    logic [DATA_W-1:0] wr_log  [0:63];
    logic [DATA_W-1:0] dac_log [0:63];
    logic              prev_busy  = 1'b0;
    logic              prev_rdclr = 1'b0;

    always @(negedge clk) begin
        if (mon_clr) begin
            wr_n <= 0; dac_n <= 0; done_n <= 0; rdreq_n <= 0; rdclr_cyc <= 0;
            rdclr_rise <= 0; full_viol <= 0; under_reqs <= 0; done_cyc <= -1; fall_cyc <= -1;
        end else begin
            if (wrfifo_wren) begin
                wr_log[wr_n % 64] <= wrfifo_din;
                wr_n              <= wr_n + 1;
            end
            if (dac_data_vld) begin
                dac_log[dac_n % 64] <= dac_data;
                dac_n               <= dac_n + 1;
            end
            if (play_done_pulse) begin
                done_n   <= done_n + 1;
                done_cyc <= cyc;
            end
            if (eth_rxfifo_rdreq)                rdreq_n    <= rdreq_n + 1;
            if (eth_rxfifo_rdreq && wrfifo_full) full_viol  <= full_viol + 1;
            if (rdfifo_clr)                      rdclr_cyc  <= rdclr_cyc + 1;
            if (rdfifo_clr && !prev_rdclr)       rdclr_rise <= rdclr_rise + 1;
            if (prev_busy && !play_busy)         fall_cyc   <= cyc;
            if (force_rd_empty && dac_data_req)  under_reqs <= under_reqs + 1;
        end
        prev_busy  <= play_busy;
        prev_rdclr <= rdfifo_clr;
    end

    int n_vec = 0;
    int n_err = 0;
    int snap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task mon_reset();
        mon_clr = 1'b1;
        @(negedge clk);
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic load_eth(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            eth_mem[eth_cnt % 64] = DATA_W'(base + i);
            eth_cnt++;
        end
    endtask

    task automatic start(input int n);
        set_play_num = 32'(n);
        start_play   = 1'b1;
        tick();
        start_play   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (play_busy && (k < 3000)) begin
            tick();
            k++;
        end
        chk(tag, play_busy, 1'b0);
    endtask

    // which: 0 = wr_n, 1 = dac_n, 2 = under_reqs
    function automatic int mon_val(input int which);
        case (which)
            0:       return wr_n;
            1:       return dac_n;
            default: return under_reqs;
        endcase
    endfunction

    task automatic wait_mon(input int which, input int target, input string tag);
        int k;
        k = 0;
        while ((mon_val(which) < target) && (k < 3000)) begin
            tick();
            k++;
        end
        chk(tag, mon_val(which) >= target, 1'b1);
    endtask

    function automatic int bad_wr(input int n, input int base, input int period);
        int b = 0;
        for (int i = 0; i < n; i++)
            if (wr_log[i] !== DATA_W'(base + (i % period))) b++;
        return b;
    endfunction

    function automatic int bad_dac(input int n, input int base, input int period);
        int b = 0;
        for (int i = 0; i < n; i++)
            if (dac_log[i] !== DATA_W'(base + (i % period))) b++;
        return b;
    endfunction

    initial begin
        reset = 1'b1; start_play = 1'b0; stop_play = 1'b0; set_play_num = 32'd0;
        loop_en = 1'b0; wrfifo_full = 1'b0;
        ticks(3);
        chk("rst_ctrl", {play_busy, eth_rxfifo_rdreq, wrfifo_wren, wrfifo_clr, rdfifo_clr,
                         rdfifo_rden, dac_data_vld, play_done_pulse, underrun_flag}, 32'd0);
        chk("rst_dac_data", dac_data, 32'd0);
        chk("rst_wr_din", wrfifo_din, 32'd0);
        reset = 1'b0;
        tick();
        mon_reset();

        // One-shot playback of 1..8
        load_eth(8, 1);
        dac_en = 1'b1;
        start(8);
        chk("t1_busy", play_busy, 1'b1);
        wait_idle("t1_idle");
        ticks(2);
        chk("t1_wr_n", wr_n, 8);
        chk("t1_wr_data", bad_wr(8, 1, 8), 0);
        chk("t1_dac_n", dac_n, 8);
        chk("t1_dac_data", bad_dac(8, 1, 8), 0);
        chk("t1_done_n", done_n, 1);
        chk("t1_busy_fall", fall_cyc - done_cyc, 1);
        chk("t1_no_underrun", underrun_flag, 1'b0);
        chk("t1_last_dac", dac_data, 16'd8);

        // Looped playback: three passes of 1..4
        mon_reset();
        load_eth(4, 1);
        loop_en = 1'b1;
        start(4);
        wait_mon(1, 9, "t2_pass3");
        loop_en = 1'b0;
        wait_idle("t2_idle");
        ticks(2);
        chk("t2_dac_n", dac_n, 12);
        chk("t2_dac_data", bad_dac(12, 1, 4), 0);
        chk("t2_rdclr_pulses", rdclr_rise, 3);
        chk("t2_rdclr_cycles", rdclr_cyc, 9);
        chk("t2_rdreq_n", rdreq_n, 4);
        chk("t2_wr_n", wr_n, 4);
        chk("t2_done_n", done_n, 1);

        // Write FIFO backpressure mid-load
        mon_reset();
        load_eth(8, 16'h40);
        start(8);
        wait_mon(0, 3, "t3_reach3");
        wrfifo_full = 1'b1;
        ticks(2);
        snap = wr_n;
        ticks(18);
        chk("t3_stall_hold", wr_n, snap);
        wrfifo_full = 1'b0;
        wait_idle("t3_idle");
        ticks(2);
        chk("t3_full_viol", full_viol, 0);
        chk("t3_wr_n", wr_n, 8);
        chk("t3_wr_data", bad_wr(8, 16'h40, 8), 0);
        chk("t3_dac_n", dac_n, 8);
        chk("t3_dac_data", bad_dac(8, 16'h40, 8), 0);

        // Underrun during playback
        mon_reset();
        load_eth(4, 16'h80);
        start(4);
        wait_mon(1, 1, "t4_first");
        force_rd_empty = 1'b1;
        chk("t4_first_val", dac_data, 16'h80);
        wait_mon(2, 2, "t4_two_reqs");
        chk("t4_flag_set", underrun_flag, 1'b1);
        chk("t4_dac_hold", dac_data, 16'h80);
        force_rd_empty = 1'b0;
        wait_idle("t4_idle");
        ticks(2);
        chk("t4_dac_n", dac_n, 4);
        chk("t4_dac_data", bad_dac(4, 16'h80, 4), 0);
        chk("t4_done_n", done_n, 1);
        chk("t4_flag_sticky", underrun_flag, 1'b1);

        // Abort during load, then restart
        mon_reset();
        load_eth(8, 16'hA0);
        start(8);
        chk("t5_flag_clear", underrun_flag, 1'b0);
        wait_mon(0, 3, "t5_reach3");
        stop_play = 1'b1;
        tick();
        stop_play = 1'b0;
        chk("t5_stop_busy", play_busy, 1'b0);
        chk("t5_stop_rdreq", eth_rxfifo_rdreq, 1'b0);
        ticks(5);
        chk("t5_no_done", done_n, 0);
        eth_flush = 1'b1;
        tick();
        eth_flush = 1'b0;
        mon_reset();
        load_eth(2, 16'hC0);
        start(2);
        wait_idle("t5_idle");
        ticks(2);
        chk("t5_wr_n", wr_n, 2);
        chk("t5_wr_data", bad_wr(2, 16'hC0, 2), 0);
        chk("t5_dac_n", dac_n, 2);
        chk("t5_dac_data", bad_dac(2, 16'hC0, 2), 0);
        chk("t5_done_n", done_n, 1);

        // Async reset mid-play, zero-length start, start+stop in idle
        mon_reset();
        load_eth(4, 16'hE0);
        start(4);
        wait_mon(1, 2, "t6_playing");
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_ctrl", {play_busy, eth_rxfifo_rdreq, wrfifo_wren, wrfifo_clr, rdfifo_clr,
                            rdfifo_rden, dac_data_vld, play_done_pulse, underrun_flag}, 32'd0);
        chk("t6_rst_dac_data", dac_data, 32'd0);
        ticks(2);
        reset = 1'b0;
        tick();
        start(0);
        ticks(3);
        chk("t6_n0_busy", play_busy, 1'b0);
        set_play_num = 32'd4;
        start_play   = 1'b1;
        stop_play    = 1'b1;
        tick();
        start_play   = 1'b0;
        stop_play    = 1'b0;
        ticks(2);
        chk("t6_startstop_busy", play_busy, 1'b0);
        chk("t6_no_done", done_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
